// File: rtl/fifo_nibble_reader_if.sv
// Read-side bundle for fifo_nibble_reader: the syncFIFO pop interface
// (r_en/dout/empty) and the packed-word valid/ready output stream.
// master = the reader, slave = the FIFO plus downstream consumer.
interface fifo_nibble_reader_if #(
  parameter int DATA_W = 4,
  parameter int PACK   = 2
);
  logic                     fifo_empty;
  logic                     r_en;
  logic [DATA_W-1:0]        fifo_dout;
  logic [DATA_W*PACK-1:0]   m_data;
  logic                     m_valid;
  logic                     m_ready;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output r_en, m_data, m_valid
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  r_en, m_data, m_valid
  );
endinterface

// File: rtl/fifo_nibble_reader.sv
// Pops nibbles from the 4-bit syncFIFO, packs PACK of them per word
// (first popped nibble in the least significant position), buffers finished
// words in a BUF_DEPTH-entry queue and offers them on a valid/ready stream.
// A word still being assembled reserves a queue slot, so the reader never
// pops data it could not store, and never pops an empty FIFO.
module fifo_nibble_reader #(
  parameter int DATA_W    = 4,
  parameter int PACK      = 2,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 r_clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 flush,
  fifo_nibble_reader_if.master bus,
  output logic [CNT_W-1:0]     word_count
);

  localparam int WORD_W = DATA_W * PACK;
  localparam int PART_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int QCNT_W = $clog2(BUF_DEPTH + 1);

  logic [PART_W-1:0] part_cnt;
  logic [WORD_W-1:0] part_data;
  logic [WORD_W-1:0] next_word;
  logic              in_flight;
  logic [WORD_W-1:0] q_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [QCNT_W-1:0] q_count;
  logic [QCNT_W:0]   q_demand;
  logic              pop;
  logic              push;
  logic              pending;
  logic              last_nibble;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign bus.m_valid = (q_count != '0);
  assign bus.m_data  = q_mem[rd_ptr];
  assign pop         = bus.m_valid & bus.m_ready;

  // Queue occupancy after this cycle's drain, plus one slot for any word in
  // progress; a new pop is allowed only while that stays below the depth.
  assign pending  = (part_cnt != '0) | in_flight;
  assign q_demand = {1'b0, q_count} - {{QCNT_W{1'b0}}, pop}
                  + {{QCNT_W{1'b0}}, pending};

  // Gated by rstn so nothing is popped while the reader is held in reset.
  assign bus.r_en = rstn & enable & ~flush & ~bus.fifo_empty
                  & (q_demand < (QCNT_W + 1)'(BUF_DEPTH));

  assign last_nibble = (part_cnt == PART_W'(PACK - 1));
  assign push        = in_flight & last_nibble;

  // Merge the arriving nibble into the partial word at its slot.
  always_comb begin
    next_word = part_data;
    for (int k = 0; k < PACK; k++) begin
      if (part_cnt == PART_W'(k)) begin
        next_word[k*DATA_W +: DATA_W] = bus.fifo_dout;
      end
    end
  end

  // Capture in-flight nibbles and track how many of the current word are held.
  always_ff @(posedge r_clk) begin
    if (!rstn) begin
      part_cnt  <= '0;
      part_data <= '0;
      in_flight <= 1'b0;
    end else if (flush) begin
      part_cnt  <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= bus.r_en;
      if (in_flight) begin
        part_data <= next_word;
        part_cnt  <= last_nibble ? '0 : part_cnt + 1'b1;
      end
    end
  end

  // Output queue: push completed words, pop on accept, both in one edge allowed.
  always_ff @(posedge r_clk) begin
    if (!rstn) begin
      for (int i = 0; i < BUF_DEPTH; i++) q_mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) begin
        q_mem[wr_ptr] <= next_word;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push & ~pop)      q_count <= q_count + 1'b1;
      else if (pop & ~push) q_count <= q_count - 1'b1;
    end
  end

  // Count words accepted downstream; flush does not touch the count.
  always_ff @(posedge r_clk) begin
    if (!rstn)    word_count <= '0;
    else if (pop) word_count <= word_count + 1'b1;
  end

endmodule
